// File: rtl/pipeline_pkg.sv
// Shared constants for the RV32I pipeline: datapath width, write-back select
// encodings and load funct3 codes.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align_ext.sv
// Combinational load alignment: picks the addressed byte/half of a little-endian
// data word, sign- or zero-extends it, and flags misaligned halfword/word accesses.
module load_align_ext
    import pipeline_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_word[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[i_addr];
    // Half select ignores addr[0]; a misaligned access still reads the truncated half.
    assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data     = i_word;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'd0, w_byte};
            F3_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr[0];
            end
            F3_LHU: begin
                o_data     = {16'd0, w_half};
                o_misalign = i_addr[0];
            end
            F3_LW: begin
                o_data     = i_word;
                o_misalign = (i_addr != 2'b00);
            end
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_wb_reg.sv
// MEM/WB pipeline register: registers MEM-stage results for write-back, aligns
// load data, qualifies the regfile write and counts retired instructions.
module pipeline_mem_wb_reg
    import pipeline_pkg::*;
#(
    parameter int XLEN  = pipeline_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_MEMWB,
    input  logic             flush_MEMWB,
    input  logic             valid_in_MEM,
    input  logic [XLEN-1:0]  PC4_in_MEM,
    input  logic [XLEN-1:0]  ALU_in_MEM,
    input  logic [XLEN-1:0]  Dmem_raw_MEM,
    input  logic [1:0]       MemtoReg_in_MEM,
    input  logic             RegWrite_in_MEM,
    input  logic [4:0]       Rd_addr_in_MEM,
    input  logic [2:0]       funct3_in_MEM,
    output logic [XLEN-1:0]  PC4_out_WB,
    output logic [XLEN-1:0]  ALU_out_WB,
    output logic [XLEN-1:0]  Dmem_data_WB,
    output logic [1:0]       MemtoReg_out_WB,
    output logic             RegWrite_out_WB,
    output logic [4:0]       Rd_addr_out_WB,
    output logic             valid_out_WB,
    output logic             misalign_WB,
    output logic [CNT_W-1:0] retired_cnt
);

    logic [XLEN-1:0]  r_pc4;
    logic [XLEN-1:0]  r_alu;
    logic [XLEN-1:0]  r_dmem;
    logic [1:0]       r_mtr;
    logic             r_regwrite;
    logic [4:0]       r_rd;
    logic             r_valid;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]     w_ext_data;
    logic            w_ext_misalign;
    logic            w_is_load;
    logic [XLEN-1:0] w_dmem_next;
    logic            w_misalign_next;
    logic            w_regwrite_next;

    load_align_ext u_align (
        .i_word     (Dmem_raw_MEM[31:0]),
        .i_addr     (ALU_in_MEM[1:0]),
        .i_funct3   (funct3_in_MEM),
        .o_data     (w_ext_data),
        .o_misalign (w_ext_misalign)
    );

    assign w_is_load       = (MemtoReg_in_MEM == MTR_MEM);
    assign w_dmem_next     = w_is_load ? XLEN'(w_ext_data) : Dmem_raw_MEM;
    assign w_misalign_next = valid_in_MEM & w_is_load & w_ext_misalign;
    // Writes to x0 are dropped here so WB never has to look at rd.
    assign w_regwrite_next = RegWrite_in_MEM & valid_in_MEM & (Rd_addr_in_MEM != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc4      <= '0;
            r_alu      <= '0;
            r_dmem     <= '0;
            r_mtr      <= '0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else if (flush_MEMWB) begin
            r_pc4      <= '0;
            r_alu      <= '0;
            r_dmem     <= '0;
            r_mtr      <= '0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (!stall_MEMWB) begin
            r_pc4      <= PC4_in_MEM;
            r_alu      <= ALU_in_MEM;
            r_dmem     <= w_dmem_next;
            r_mtr      <= MemtoReg_in_MEM;
            r_regwrite <= w_regwrite_next;
            r_rd       <= Rd_addr_in_MEM;
            r_valid    <= valid_in_MEM;
            r_misalign <= w_misalign_next;
            if (valid_in_MEM)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign PC4_out_WB      = r_pc4;
    assign ALU_out_WB      = r_alu;
    assign Dmem_data_WB    = r_dmem;
    assign MemtoReg_out_WB = r_mtr;
    assign RegWrite_out_WB = r_regwrite;
    assign Rd_addr_out_WB  = r_rd;
    assign valid_out_WB    = r_valid;
    assign misalign_WB     = r_misalign;
    assign retired_cnt     = r_cnt;

endmodule

// File: tb/tb_pipeline_mem_wb_reg.sv
// Directed bench for the MEM/WB register; a 4-bit retired counter keeps the wrap reachable.
module tb_pipeline_mem_wb_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall_MEMWB;
    logic             flush_MEMWB;
    logic             valid_in_MEM;
    logic [XLEN-1:0]  PC4_in_MEM;
    logic [XLEN-1:0]  ALU_in_MEM;
    logic [XLEN-1:0]  Dmem_raw_MEM;
    logic [1:0]       MemtoReg_in_MEM;
    logic             RegWrite_in_MEM;
    logic [4:0]       Rd_addr_in_MEM;
    logic [2:0]       funct3_in_MEM;
    logic [XLEN-1:0]  PC4_out_WB;
    logic [XLEN-1:0]  ALU_out_WB;
    logic [XLEN-1:0]  Dmem_data_WB;
    logic [1:0]       MemtoReg_out_WB;
    logic             RegWrite_out_WB;
    logic [4:0]       Rd_addr_out_WB;
    logic             valid_out_WB;
    logic             misalign_WB;
    logic [CNT_W-1:0] retired_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    pipeline_mem_wb_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_MEMWB     (stall_MEMWB),
        .flush_MEMWB     (flush_MEMWB),
        .valid_in_MEM    (valid_in_MEM),
        .PC4_in_MEM      (PC4_in_MEM),
        .ALU_in_MEM      (ALU_in_MEM),
        .Dmem_raw_MEM    (Dmem_raw_MEM),
        .MemtoReg_in_MEM (MemtoReg_in_MEM),
        .RegWrite_in_MEM (RegWrite_in_MEM),
        .Rd_addr_in_MEM  (Rd_addr_in_MEM),
        .funct3_in_MEM   (funct3_in_MEM),
        .PC4_out_WB      (PC4_out_WB),
        .ALU_out_WB      (ALU_out_WB),
        .Dmem_data_WB    (Dmem_data_WB),
        .MemtoReg_out_WB (MemtoReg_out_WB),
        .RegWrite_out_WB (RegWrite_out_WB),
        .Rd_addr_out_WB  (Rd_addr_out_WB),
        .valid_out_WB    (valid_out_WB),
        .misalign_WB     (misalign_WB),
        .retired_cnt     (retired_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [31:0] raw, input logic [1:0] mtr, input logic rw,
                         input logic [4:0] rd, input logic [2:0] f3);
        valid_in_MEM    = v;
        PC4_in_MEM      = pc4;
        ALU_in_MEM      = alu;
        Dmem_raw_MEM    = raw;
        MemtoReg_in_MEM = mtr;
        RegWrite_in_MEM = rw;
        Rd_addr_in_MEM  = rd;
        funct3_in_MEM   = f3;
    endtask

    initial begin
        // 1: reset with every input high
        rst_n = 1'b0; stall_MEMWB = 1'b1; flush_MEMWB = 1'b1;
        drive(1'b1, '1, '1, '1, 2'b11, 1'b1, 5'h1F, 3'b111);
        step();
        chk("rst_pc4", PC4_out_WB, 32'h0);
        chk("rst_alu", ALU_out_WB, 32'h0);
        chk("rst_dmem", Dmem_data_WB, 32'h0);
        chk("rst_mtr", 32'(MemtoReg_out_WB), 32'h0);
        chk("rst_rw", 32'(RegWrite_out_WB), 32'h0);
        chk("rst_rd", 32'(Rd_addr_out_WB), 32'h0);
        chk("rst_valid", 32'(valid_out_WB), 32'h0);
        chk("rst_mis", 32'(misalign_WB), 32'h0);
        chk("rst_cnt", 32'(retired_cnt), 32'h0);
        $display("reset: cnt=%0d valid=%0b", retired_cnt, valid_out_WB);
        exp_cnt = '0;
        rst_n = 1'b1; stall_MEMWB = 1'b0; flush_MEMWB = 1'b0;

        // 2: byte loads
        drive(1'b1, 32'h104, 32'h1003, 32'h80FF_1234, 2'b01, 1'b1, 5'd7, 3'b000);
        step(); exp_cnt++;
        chk("lb_data", Dmem_data_WB, 32'hFFFF_FF80);
        chk("lb_pc4", PC4_out_WB, 32'h104);
        chk("lb_alu", ALU_out_WB, 32'h1003);
        chk("lb_mtr", 32'(MemtoReg_out_WB), 32'h1);
        chk("lb_rd", 32'(Rd_addr_out_WB), 32'd7);
        chk("lb_rw", 32'(RegWrite_out_WB), 32'h1);
        chk("lb_valid", 32'(valid_out_WB), 32'h1);
        chk("lb_mis", 32'(misalign_WB), 32'h0);
        chk("lb_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("LB : data=%h cnt=%0d", Dmem_data_WB, retired_cnt);

        funct3_in_MEM = 3'b100;
        step(); exp_cnt++;
        chk("lbu_data", Dmem_data_WB, 32'h0000_0080);
        chk("lbu_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("LBU: data=%h cnt=%0d", Dmem_data_WB, retired_cnt);

        // 3: halfword / word loads, misalignment
        drive(1'b1, 32'h108, 32'h1002, 32'h8001_7FFF, 2'b01, 1'b1, 5'd8, 3'b001);
        step(); exp_cnt++;
        chk("lh_data", Dmem_data_WB, 32'hFFFF_8001);
        chk("lh_mis", 32'(misalign_WB), 32'h0);
        $display("LH : data=%h mis=%0b", Dmem_data_WB, misalign_WB);

        ALU_in_MEM = 32'h1001;
        step(); exp_cnt++;
        chk("lh_odd_mis", 32'(misalign_WB), 32'h1);
        chk("lh_odd_data", Dmem_data_WB, 32'h0000_7FFF);
        $display("LH@1: data=%h mis=%0b", Dmem_data_WB, misalign_WB);

        ALU_in_MEM = 32'h1000; funct3_in_MEM = 3'b010;
        step(); exp_cnt++;
        chk("lw_data", Dmem_data_WB, 32'h8001_7FFF);
        chk("lw_mis", 32'(misalign_WB), 32'h0);
        chk("lw_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("LW : data=%h cnt=%0d", Dmem_data_WB, retired_cnt);

        ALU_in_MEM = 32'h1006;
        step(); exp_cnt++;
        chk("lw_odd_mis", 32'(misalign_WB), 32'h1);
        chk("lw_odd_data", Dmem_data_WB, 32'h8001_7FFF);
        $display("LW@2: data=%h mis=%0b", Dmem_data_WB, misalign_WB);

        // non-load select: raw word passes, no misalign even with odd LH address
        drive(1'b1, 32'h10C, 32'h2003, 32'h80FF_1234, 2'b00, 1'b1, 5'd3, 3'b001);
        step(); exp_cnt++;
        chk("alu_sel_data", Dmem_data_WB, 32'h80FF_1234);
        chk("alu_sel_mis", 32'(misalign_WB), 32'h0);
        $display("ALU sel: data=%h mis=%0b", Dmem_data_WB, misalign_WB);

        // invalid instruction: no misalign, no write, counter held
        drive(1'b0, 32'h110, 32'h2001, 32'h1111_2222, 2'b01, 1'b1, 5'd4, 3'b001);
        step();
        chk("inv_mis", 32'(misalign_WB), 32'h0);
        chk("inv_rw", 32'(RegWrite_out_WB), 32'h0);
        chk("inv_valid", 32'(valid_out_WB), 32'h0);
        chk("inv_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("invalid: valid=%0b cnt=%0d", valid_out_WB, retired_cnt);

        // 4: stall holds everything
        drive(1'b1, 32'h114, 32'h3000, 32'hCAFE_BABE, 2'b01, 1'b1, 5'd9, 3'b010);
        step(); exp_cnt++;
        chk("pre_stall_data", Dmem_data_WB, 32'hCAFE_BABE);
        stall_MEMWB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 32'h4000 + 32'(i), 32'h5555_0000 + 32'(i),
                  2'b10, 1'b1, 5'd10 + 5'(i), 3'b000);
            step();
            chk("stall_data", Dmem_data_WB, 32'hCAFE_BABE);
            chk("stall_rd", 32'(Rd_addr_out_WB), 32'd9);
            chk("stall_pc4", PC4_out_WB, 32'h114);
            chk("stall_cnt", 32'(retired_cnt), 32'(exp_cnt));
            $display("stall %0d: data=%h cnt=%0d", i, Dmem_data_WB, retired_cnt);
        end
        stall_MEMWB = 1'b0;
        drive(1'b1, 32'h118, 32'h3002, 32'hABCD_0000, 2'b01, 1'b1, 5'd11, 3'b101);
        step(); exp_cnt++;
        chk("release_data", Dmem_data_WB, 32'h0000_ABCD);
        chk("release_rd", 32'(Rd_addr_out_WB), 32'd11);
        chk("release_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("release: data=%h cnt=%0d", Dmem_data_WB, retired_cnt);

        // 5: flush and flush+stall both insert bubbles
        flush_MEMWB = 1'b1;
        drive(1'b1, 32'h500, 32'h600, 32'h700, 2'b10, 1'b1, 5'd5, 3'b010);
        step();
        chk("flush_valid", 32'(valid_out_WB), 32'h0);
        chk("flush_rw", 32'(RegWrite_out_WB), 32'h0);
        chk("flush_pc4", PC4_out_WB, 32'h0);
        chk("flush_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("flush: valid=%0b rw=%0b cnt=%0d", valid_out_WB, RegWrite_out_WB, retired_cnt);
        flush_MEMWB = 1'b0;
        step(); exp_cnt++;
        chk("post_flush_pc4", PC4_out_WB, 32'h500);
        chk("post_flush_valid", 32'(valid_out_WB), 32'h1);
        flush_MEMWB = 1'b1; stall_MEMWB = 1'b1;
        step();
        chk("fs_valid", 32'(valid_out_WB), 32'h0);
        chk("fs_rw", 32'(RegWrite_out_WB), 32'h0);
        chk("fs_pc4", PC4_out_WB, 32'h0);
        chk("fs_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("flush+stall: valid=%0b cnt=%0d", valid_out_WB, retired_cnt);
        flush_MEMWB = 1'b0; stall_MEMWB = 1'b0;

        // 6: rd=x0 suppresses write but still retires; then counter wrap
        drive(1'b1, 32'h804, 32'h0, 32'h0, 2'b00, 1'b1, 5'd0, 3'b010);
        step(); exp_cnt++;
        chk("x0_rw", 32'(RegWrite_out_WB), 32'h0);
        chk("x0_valid", 32'(valid_out_WB), 32'h1);
        chk("x0_cnt", 32'(retired_cnt), 32'(exp_cnt));
        $display("x0: rw=%0b cnt=%0d", RegWrite_out_WB, retired_cnt);
        Rd_addr_in_MEM = 5'd1;
        while (exp_cnt != '1) begin
            step(); exp_cnt++;
            chk("fill_cnt", 32'(retired_cnt), 32'(exp_cnt));
        end
        chk("max_cnt", 32'(retired_cnt), 32'hF);
        step();
        chk("wrap_cnt", 32'(retired_cnt), 32'h0);
        chk("wrap_rw", 32'(RegWrite_out_WB), 32'h1);
        $display("wrap: cnt=%0d", retired_cnt);

        // reset during stall discards state; first cycle after loads normally
        drive(1'b1, 32'h900, 32'h3001, 32'h1234_5678, 2'b01, 1'b1, 5'd12, 3'b000);
        step();
        stall_MEMWB = 1'b1; rst_n = 1'b0;
        step();
        chk("rst_stall_valid", 32'(valid_out_WB), 32'h0);
        chk("rst_stall_pc4", PC4_out_WB, 32'h0);
        chk("rst_stall_cnt", 32'(retired_cnt), 32'h0);
        rst_n = 1'b1; stall_MEMWB = 1'b0;
        step();
        chk("post_rst_data", Dmem_data_WB, 32'h0000_0056);
        chk("post_rst_cnt", 32'(retired_cnt), 32'h1);
        chk("post_rst_rd", 32'(Rd_addr_out_WB), 32'd12);
        $display("post-reset: data=%h cnt=%0d", Dmem_data_WB, retired_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
